gpio_wb: RTL and testbench

Parametrised Wishbone GPIO peripheral, next generation of the 4-bit in/out port on the SoC Wishbone bus. It provides:

- WIDTH bidirectional pins with per-pin direction.
- Atomic set/clear of output bits.
- Multi-stage input synchronisers.
- Per-pin rising/falling edge interrupt capture with a write-1-to-clear status register and a single level interrupt output.

Accesses are single-beat, with a registered one-cycle acknowledge.

---
 rtl/gpio_wb.sv | 206 ++++++++++++++++++++
 tb/tb_gpio_wb.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_wb.sv
// -----------------------------------------------------------------------------
// gpio_wb - Wishbone GPIO peripheral
//
// WIDTH bidirectional pins with per-pin direction, atomic set/clear of the
// output register, multi-stage input synchronisers and per-pin rising/falling
// edge interrupt capture with a write-1-to-clear status register.
// Single-beat Wishbone accesses with a registered one-cycle acknowledge.
//
// Register map (word index = i_wb_adr[4:2]):
//   0 OUT        r/w  output data
//   1 IN         r    synchronised pin value (writes ignored)
//   2 DIR        r/w  direction, 1 = output
//   3 SET        w    OUT |= data (reads 0)
//   4 CLR        w    OUT &= ~data (reads 0)
//   5 RISE_EN    r/w  rising-edge interrupt enable
//   6 FALL_EN    r/w  falling-edge interrupt enable
//   7 IRQ_STATUS r/w1c captured edge events
//
// Ports:
//   i_wb_clk    in   1      clock, all logic on the rising edge
//   i_wb_rst    in   1      asynchronous active-high reset
//   i_wb_adr    in   32     byte address, only [4:2] decoded
//   i_wb_dat    in   32     write data, bits above WIDTH ignored
//   i_wb_we     in   1      1 = write, 0 = read
//   i_wb_stb    in   1      access request, held until ack
//   o_wb_rdt    out  32     read data, valid while o_wb_ack = 1
//   o_wb_ack    out  1      one-cycle acknowledge
//   i_gpio_in   in   WIDTH  asynchronous pin inputs
//   o_gpio_out  out  WIDTH  output data register
//   o_gpio_oe   out  WIDTH  output enable (direction register)
//   o_irq       out  1      OR of all IRQ_STATUS bits
// -----------------------------------------------------------------------------
module gpio_wb #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst,
    input  logic [31:0]      i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic             i_wb_we,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio_in,
    output logic [WIDTH-1:0] o_gpio_out,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);

    typedef enum logic [2:0] {
        REG_OUT     = 3'd0,
        REG_IN      = 3'd1,
        REG_DIR     = 3'd2,
        REG_SET     = 3'd3,
        REG_CLR     = 3'd4,
        REG_RISE_EN = 3'd5,
        REG_FALL_EN = 3'd6,
        REG_STATUS  = 3'd7
    } reg_idx_e;

    // -------------------------------------------------------------------------
    // Register state
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             ack_q;
    logic [31:0]      rdt_q;

    // Synchroniser chain; index 0 is the flop nearest the pin.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  sync_s;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    reg_idx_e         sel;
    logic             accept;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] event_hit;

    // Address bits outside [4:2] and data bits above WIDTH are intentionally
    // don't-care; folding them here keeps them visibly accounted for.
    logic unused_bits;
    assign unused_bits = ^{i_wb_adr[31:5], i_wb_adr[1:0], i_wb_dat >> WIDTH};

    assign sel     = reg_idx_e'(i_wb_adr[4:2]);
    // A held stb is only taken while ack is low, so each ack carries exactly
    // one access and a continuous stb yields an ack every second cycle.
    assign accept  = i_wb_stb & ~ack_q;
    assign wr_en   = accept & i_wb_we;
    assign wr_data = i_wb_dat[WIDTH-1:0];

    // -------------------------------------------------------------------------
    // Edge detection on the synchronised inputs
    // -------------------------------------------------------------------------
    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign rise      = sync_s & ~prev_q;
    assign fall      = ~sync_s & prev_q;
    assign event_hit = (rise & rise_en_q) | (fall & fall_en_q);

    // -------------------------------------------------------------------------
    // Read mux: always reflects the pre-update register values, so a read on
    // the same edge as a write/event returns the old contents.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // before any branch; a path that leaves it unassigned infers a latch.
        rd_val = '0;
        case (sel)
            REG_OUT:     rd_val = out_q;
            REG_IN:      rd_val = sync_s;
            REG_DIR:     rd_val = dir_q;
            REG_RISE_EN: rd_val = rise_en_q;
            REG_FALL_EN: rd_val = fall_en_q;
            REG_STATUS:  rd_val = status_q;
            default:     rd_val = '0; // SET / CLR are write-only
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state for the software-visible registers
    // -------------------------------------------------------------------------
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_mask  = '0;
        if (wr_en) begin
            case (sel)
                REG_OUT:     out_d     = wr_data;
                REG_DIR:     dir_d     = wr_data;
                REG_SET:     out_d     = out_q | wr_data;
                REG_CLR:     out_d     = out_q & ~wr_data;
                REG_RISE_EN: rise_en_d = wr_data;
                REG_FALL_EN: fall_en_d = wr_data;
                REG_STATUS:  w1c_mask  = wr_data;
                default:     ; // IN is read-only
            endcase
        end
        // A new event wins over a same-edge write-1-to-clear of that bit.
        status_d = event_hit | (status_q & ~w1c_mask);
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (i_wb_rst) begin
            out_q     <= RESET_OUT;
            dir_q     <= RESET_DIR;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            ack_q     <= 1'b0;
            rdt_q     <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            ack_q     <= accept;
            if (accept) begin
                rdt_q <= 32'(rd_val);
            end
        end
    end

    // Synchroniser and edge-history flops. Reset to 0 so that pins already
    // high at reset release produce a rise, which is harmless because the
    // enables also reset to 0.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_gpio_in};
            prev_q <= sync_s;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_wb_rdt   = rdt_q;
    assign o_wb_ack   = ack_q;
    assign o_gpio_out = out_q;
    assign o_gpio_oe  = dir_q;
    assign o_irq      = |status_q;

endmodule

// File: tb/tb_gpio_wb.sv
// -----------------------------------------------------------------------------
// tb_gpio_wb - self-checking bench for gpio_wb (WIDTH=8, SYNC_STAGES=2,
// RESET_OUT=0xA5, RESET_DIR=0x0F). A behavioural model tracks the register
// file and keeps a history of sampled pin values; per-scenario tasks compare
// the DUT against the model and against fixed expected values.
// -----------------------------------------------------------------------------
module tb_gpio_wb;

    localparam int         W  = 8;
    localparam int         S  = 2;
    localparam logic [7:0] RST_OUT = 8'hA5;
    localparam logic [7:0] RST_DIR = 8'h0F;

    localparam logic [2:0] A_OUT = 3'd0, A_IN = 3'd1, A_DIR = 3'd2, A_SET = 3'd3,
                           A_CLR = 3'd4, A_RISE = 3'd5, A_FALL = 3'd6, A_STAT = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   adr = '0;
    logic [31:0]   dat = '0;
    logic          we  = 1'b0;
    logic          stb = 1'b0;
    logic [31:0]   rdt;
    logic          ack;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    gpio_wb #(
        .WIDTH      (W),
        .SYNC_STAGES(S),
        .RESET_OUT  (RST_OUT),
        .RESET_DIR  (RST_DIR)
    ) dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (rst),
        .i_wb_adr  (adr),
        .i_wb_dat  (dat),
        .i_wb_we   (we),
        .i_wb_stb  (stb),
        .o_wb_rdt  (rdt),
        .o_wb_ack  (ack),
        .i_gpio_in (gpio_in),
        .o_gpio_out(gpio_out),
        .o_gpio_oe (gpio_oe),
        .o_irq     (irq)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model. hist[k] is the pin value sampled k edges ago (hist[0]
    // newest); the synchronised value is the sample from S-1 edges back and
    // its one-cycle-older copy is hist[S].
    // -------------------------------------------------------------------------
    logic [7:0]  m_out, m_dir, m_rise, m_fall, m_stat;
    logic        m_ack;
    logic [31:0] m_rdt;
    logic [7:0]  hist [0:S];
    logic [7:0]  m_s, m_p, m_ev, m_wd;
    logic        m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out  = RST_OUT;
            m_dir  = RST_DIR;
            m_rise = '0;
            m_fall = '0;
            m_stat = '0;
            m_ack  = 1'b0;
            m_rdt  = '0;
            for (int i = 0; i <= S; i++) hist[i] = '0;
        end else begin
            m_s   = hist[S-1];
            m_p   = hist[S];
            m_ev  = (m_s & ~m_p & m_rise) | (~m_s & m_p & m_fall);
            m_acc = stb && !m_ack;
            m_wd  = dat[7:0];
            if (m_acc) begin
                case (adr[4:2])
                    A_OUT:   m_rdt = {24'd0, m_out};
                    A_IN:    m_rdt = {24'd0, m_s};
                    A_DIR:   m_rdt = {24'd0, m_dir};
                    A_RISE:  m_rdt = {24'd0, m_rise};
                    A_FALL:  m_rdt = {24'd0, m_fall};
                    A_STAT:  m_rdt = {24'd0, m_stat};
                    default: m_rdt = 32'd0;
                endcase
                if (we) begin
                    case (adr[4:2])
                        A_OUT:  m_out  = m_wd;
                        A_DIR:  m_dir  = m_wd;
                        A_SET:  m_out  = m_out | m_wd;
                        A_CLR:  m_out  = m_out & ~m_wd;
                        A_RISE: m_rise = m_wd;
                        A_FALL: m_fall = m_wd;
                        A_STAT: m_stat = m_stat & ~m_wd;
                        default: ;
                    endcase
                end
            end
            m_stat = m_stat | m_ev;
            m_ack  = m_acc;
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = gpio_in;
        end
    end

    // -------------------------------------------------------------------------
    // Bus transfer: drives one access, checks ack timing, read data and the
    // pin-side outputs against the model.
    // -------------------------------------------------------------------------
    task automatic wb_xfer(input logic wr, input logic [2:0] idx, input logic [31:0] wdata,
                           output logic [31:0] rdata);
        @(negedge clk);
        stb = 1'b1;
        we  = wr;
        adr = $urandom();
        adr[4:2] = idx;
        dat = wdata;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL xfer_ack_rise idx=%0d: ack=%b expected 1", idx, ack);
        end
        checks++;
        if (rdt !== m_rdt) begin
            failures++;
            $display("FAIL xfer_rdata idx=%0d: got %h expected %h", idx, rdt, m_rdt);
        end
        rdata = rdt;
        @(negedge clk);
        stb = 1'b0;
        we  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0) begin
            failures++;
            $display("FAIL xfer_ack_width idx=%0d: ack=%b expected 0", idx, ack);
        end
        checks++;
        if ({gpio_out, gpio_oe, irq} !== {m_out, m_dir, |m_stat}) begin
            failures++;
            $display("FAIL xfer_state idx=%0d: out=%h oe=%h irq=%b expected out=%h oe=%h irq=%b",
                     idx, gpio_out, gpio_oe, irq, m_out, m_dir, |m_stat);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] r;
        wb_xfer(1'b1, A_OUT,  32'h5A, r);
        wb_xfer(1'b1, A_DIR,  32'hFF, r);
        wb_xfer(1'b1, A_RISE, 32'hFF, r);
        @(negedge clk); gpio_in = 8'hFF;
        idle(4); #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_irq: irq=%b expected 1", irq);
        end
        // Assert reset mid-cycle, away from any clock edge.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (gpio_out !== 8'hA5 || gpio_oe !== 8'h0F) begin
            failures++;
            $display("FAIL reset_regs: out=%h oe=%h expected out=a5 oe=0f", gpio_out, gpio_oe);
        end
        checks++;
        if (ack !== 1'b0 || irq !== 1'b0 || rdt !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b irq=%b rdt=%h expected 0/0/0", ack, irq, rdt);
        end
        idle(2);
        @(negedge clk); rst = 1'b0;
        // Pins are still high: the synchroniser rise must not be captured.
        idle(5); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_irq: irq=%b expected 0", irq);
        end
        wb_xfer(1'b0, A_STAT, 32'd0, r);
        checks++;
        if (r !== 32'd0) begin
            failures++;
            $display("FAIL reset_status: got %h expected 0", r);
        end
        wb_xfer(1'b0, A_OUT, 32'd0, r);
        checks++;
        if (r !== 32'hA5) begin
            failures++;
            $display("FAIL reset_out_read: got %h expected a5", r);
        end
    endtask

    task automatic test_registers();
        logic [31:0] r;
        wb_xfer(1'b1, A_OUT, 32'hFFFF_FF3C, r);
        wb_xfer(1'b1, A_SET, 32'h0000_0001, r);
        wb_xfer(1'b1, A_CLR, 32'h0000_000C, r);
        checks++;
        if (gpio_out !== 8'h31) begin
            failures++;
            $display("FAIL reg_set_clr: out=%h expected 31", gpio_out);
        end
        wb_xfer(1'b0, A_OUT, 32'd0, r);
        checks++;
        if (r !== 32'h31) begin
            failures++;
            $display("FAIL reg_read_out: got %h expected 31", r);
        end
        wb_xfer(1'b0, A_SET, 32'd0, r);
        checks++;
        if (r !== 32'd0) begin
            failures++;
            $display("FAIL reg_read_set: got %h expected 0", r);
        end
        wb_xfer(1'b1, A_DIR, 32'h0000_00C3, r);
        wb_xfer(1'b1, A_IN,  32'h0000_0055, r);
        wb_xfer(1'b0, A_DIR, 32'd0, r);
        checks++;
        if (r !== 32'hC3 || gpio_oe !== 8'hC3) begin
            failures++;
            $display("FAIL reg_dir: read=%h oe=%h expected c3", r, gpio_oe);
        end
    endtask

    task automatic test_input_latency();
        logic [31:0] r;
        @(negedge clk); gpio_in = 8'h00;
        idle(4);
        @(negedge clk); gpio_in = 8'h81;           // change before edge 1
        @(negedge clk);                             // after edge 1
        stb = 1'b1; we = 1'b0; adr = '0; adr[4:2] = A_IN;
        @(posedge clk); #1;                         // read accepted at edge 2
        checks++;
        if (ack !== 1'b1 || rdt !== 32'h00) begin
            failures++;
            $display("FAIL in_latency_early: ack=%b rdt=%h expected 1/00", ack, rdt);
        end
        @(negedge clk); stb = 1'b0;
        wb_xfer(1'b0, A_IN, 32'd0, r);              // accepted at edge 4
        checks++;
        if (r !== 32'h81) begin
            failures++;
            $display("FAIL in_latency_late: got %h expected 81", r);
        end
    endtask

    task automatic test_edge_capture();
        logic [31:0] r;
        @(negedge clk); gpio_in = 8'h80;
        wb_xfer(1'b1, A_RISE, 32'h01, r);
        wb_xfer(1'b1, A_FALL, 32'h80, r);
        wb_xfer(1'b1, A_STAT, 32'hFF, r);
        wb_xfer(1'b0, A_STAT, 32'd0, r);
        checks++;
        if (r !== 32'd0) begin
            failures++;
            $display("FAIL edge_precond: status=%h expected 0", r);
        end
        @(negedge clk); gpio_in = 8'h81;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            checks++;
            if (irq !== (e == 3)) begin
                failures++;
                $display("FAIL edge_irq_timing edge=%0d: irq=%b expected %b", e, irq, e == 3);
            end
        end
        wb_xfer(1'b0, A_STAT, 32'd0, r);
        checks++;
        if (r !== 32'h01) begin
            failures++;
            $display("FAIL edge_rise: status=%h expected 01", r);
        end
        @(negedge clk); gpio_in = 8'h01;
        idle(4);
        wb_xfer(1'b0, A_STAT, 32'd0, r);
        checks++;
        if (r !== 32'h81) begin
            failures++;
            $display("FAIL edge_fall: status=%h expected 81", r);
        end
        wb_xfer(1'b1, A_STAT, 32'h01, r);
        wb_xfer(1'b0, A_STAT, 32'd0, r);
        checks++;
        if (r !== 32'h80 || irq !== 1'b1) begin
            failures++;
            $display("FAIL edge_w1c: status=%h irq=%b expected 80/1", r, irq);
        end
    endtask

    task automatic test_clear_collision();
        logic [31:0] r;
        @(negedge clk); gpio_in = 8'h00;
        wb_xfer(1'b1, A_RISE, 32'h01, r);
        wb_xfer(1'b1, A_FALL, 32'h00, r);
        idle(3);
        wb_xfer(1'b1, A_STAT, 32'hFF, r);
        @(negedge clk); gpio_in = 8'h01;            // rise captured at edge 3
        @(posedge clk);                             // edge 1
        @(posedge clk);                             // edge 2
        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = '0; adr[4:2] = A_STAT; dat = 32'h01;
        @(posedge clk); #1;                         // W1C and rise on edge 3
        checks++;
        if (ack !== 1'b1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL collision_edge: ack=%b irq=%b expected 1/1", ack, irq);
        end
        @(negedge clk); stb = 1'b0; we = 1'b0;
        wb_xfer(1'b0, A_STAT, 32'd0, r);
        checks++;
        if (r !== 32'h01) begin
            failures++;
            $display("FAIL collision_status: status=%h expected 01", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [7:0]  vals [6] = '{8'h11, 8'hE1, 8'h22, 8'hE2, 8'h33, 8'hE3};
        int          acks;
        wb_xfer(1'b1, A_DIR, 32'h3C, r);
        acks = 0;
        @(negedge clk);
        stb = 1'b1; we = 1'b1;
        for (int c = 0; c < 6; c++) begin
            adr = $urandom();
            adr[4:2] = (c % 2 == 0) ? A_OUT : A_DIR;
            dat = {24'd0, vals[c]};
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
            @(negedge clk);
        end
        stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (acks != 3) begin
            failures++;
            $display("FAIL b2b_ack_count: got %0d expected 3", acks);
        end
        checks++;
        if (gpio_out !== 8'h33 || gpio_oe !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_writes: out=%h oe=%h expected 33/3c", gpio_out, gpio_oe);
        end
        // Reset landing inside an ack cycle drops ack at once.
        @(negedge clk);
        stb = 1'b1; we = 1'b0; adr = '0; adr[4:2] = A_OUT;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ack_before_reset: ack=%b expected 1", ack);
        end
        #2; rst = 1'b1; #1;
        checks++;
        if (ack !== 1'b0 || gpio_out !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_reset_ack: ack=%b out=%h expected 0/a5", ack, gpio_out);
        end
        @(negedge clk); stb = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk); gpio_in = 8'($urandom());
            end
            idle($urandom_range(0, 2));
            wb_xfer(1'($urandom()), 3'($urandom()), $urandom(), r);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_registers();
        test_input_latency();
        test_edge_capture();
        test_clear_collision();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
